// File: rtl/io_uart_gpio_pkg.sv
// Shared constants for the UART-to-GPIO bridge: command bytes, pad indices, frame FSM states.
package io_uart_gpio_pkg;

   localparam logic [7:0] CMD_WR = 8'h57;
   localparam logic [7:0] CMD_OE = 8'h45;
   localparam logic [7:0] CMD_RD = 8'h52;

   localparam int RX_IDX   = 0;
   localparam int TX_IDX   = 1;
   localparam int GPIO_LSB = 2;

   typedef enum logic [2:0] {
      F_IDLE,
      F_HI,
      F_LO,
      F_EXEC,
      F_RESP_HI,
      F_RESP_LO
   } frame_state_t;

endpackage

// File: rtl/uart_8n1.sv
// Purpose: 8N1 UART receive and transmit engines, LSB first.
// Latency: rx_valid one cycle after the mid-stop sample; tx line falls the cycle after tx_start.
// Backpressure: none on RX; tx_start is ignored while tx_busy, tx_done flags the last stop cycle.
module uart_8n1 #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   input  logic       tx_start,
   input  logic [7:0] tx_byte,
   output logic       rx_valid,
   output logic [7:0] rx_byte,
   output logic       rx_err,
   output logic       rx_busy,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

   localparam logic [2:0] RX_IDLE  = 3'd0;
   localparam logic [2:0] RX_START = 3'd1;
   localparam logic [2:0] RX_DATA  = 3'd2;
   localparam logic [2:0] RX_STOP  = 3'd3;
   localparam logic [2:0] RX_WAIT  = 3'd4;

   logic [2:0]    rx_state;
   logic [CW-1:0] rx_cnt;
   logic [3:0]    rx_idx;
   logic          rx_prev;
   logic [CW-1:0] tx_cnt;
   logic [3:0]    tx_idx;
   logic [9:0]    tx_frame;

   assign rx_busy = (rx_state != RX_IDLE);
   assign tx_done = tx_busy && (tx_idx == 4'd9) && (tx_cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_idx   <= '0;
         rx_prev  <= 1'b1;
         rx_byte  <= '0;
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
      end else begin
         rx_prev  <= rx;
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
         case (rx_state)
            RX_IDLE: if (rx_prev && !rx) begin
               rx_state <= RX_START;
               rx_cnt   <= '0;
            end
            RX_START: if (rx_cnt == HALF) begin
               rx_cnt   <= '0;
               rx_idx   <= '0;
               rx_state <= rx ? RX_IDLE : RX_DATA;
            end else rx_cnt <= rx_cnt + 1'b1;
            RX_DATA: if (rx_cnt == LAST) begin
               rx_cnt  <= '0;
               rx_byte <= {rx, rx_byte[7:1]};
               rx_idx  <= rx_idx + 1'b1;
               if (rx_idx == 4'd7) rx_state <= RX_STOP;
            end else rx_cnt <= rx_cnt + 1'b1;
            RX_STOP: if (rx_cnt == LAST) begin
               rx_cnt <= '0;
               if (rx) begin
                  rx_valid <= 1'b1;
                  rx_state <= RX_IDLE;
               end else begin
                  rx_err   <= 1'b1;
                  rx_state <= RX_WAIT;
               end
            end else rx_cnt <= rx_cnt + 1'b1;
            // A broken stop bit may be a held-low line; only re-arm once it is idle again.
            RX_WAIT: if (rx) rx_state <= RX_IDLE;
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx       <= 1'b1;
         tx_busy  <= 1'b0;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         tx_frame <= '1;
      end else if (!tx_busy) begin
         if (tx_start) begin
            tx_busy  <= 1'b1;
            tx_frame <= {1'b1, tx_byte, 1'b0};
            tx       <= 1'b0;
            tx_cnt   <= '0;
            tx_idx   <= '0;
         end
      end else if (tx_cnt == LAST) begin
         tx_cnt <= '0;
         if (tx_idx == 4'd9) begin
            tx_busy <= 1'b0;
            tx      <= 1'b1;
         end else begin
            tx_idx   <= tx_idx + 1'b1;
            tx_frame <= {1'b1, tx_frame[9:1]};
            tx       <= tx_frame[1];
         end
      end else begin
         tx_cnt <= tx_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/io_uart_gpio_bridge.sv
// Purpose: 3-byte UART command frames write GPIO out/oe registers or read back all 16 pads.
// Latency: register update visible the cycle after the last frame byte executes; read reply starts one cycle later.
// Backpressure: none; bytes arriving during a read reply are dropped, stalled frames time out.
module io_uart_gpio_bridge
   import io_uart_gpio_pkg::*;
#(
   parameter int CLKS_PER_BIT  = 434,
   parameter int FRAME_TO_BITS = 40
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic [15:0] io_in,
   output logic [15:0] io_out,
   output logic [15:0] io_oeb,
   output logic        frame_err_o
);
   localparam int TO_LIMIT = FRAME_TO_BITS * CLKS_PER_BIT;
   localparam int TW = $clog2(TO_LIMIT + 1);
   localparam logic [TW-1:0] TO_MAX = TW'(TO_LIMIT);

   logic [15:0]  sync1, sync2, snap;
   logic [13:0]  data, out_reg, oe_reg;
   logic [7:0]   cmd, rx_byte, tx_byte;
   logic [TW-1:0] to_cnt;
   frame_state_t state;
   logic rx_valid, rx_err, rx_busy, tx, tx_busy, tx_done, tx_start;
   logic in_frame, timeout;

   uart_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
      .clk      (wb_clk_i),
      .rst_n    (wb_rst_ni),
      .rx       (sync2[RX_IDX]),
      .tx_start (tx_start),
      .tx_byte  (tx_byte),
      .rx_valid (rx_valid),
      .rx_byte  (rx_byte),
      .rx_err   (rx_err),
      .rx_busy  (rx_busy),
      .tx       (tx),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done)
   );

   assign in_frame = (state == F_HI) || (state == F_LO);
   assign timeout  = in_frame && !rx_valid && (to_cnt == TO_MAX);
   assign tx_start = ((state == F_RESP_HI) || (state == F_RESP_LO)) && !tx_busy;
   assign tx_byte  = (state == F_RESP_HI) ? snap[15:8] : snap[7:0];

   always_comb begin
      io_out = '0;
      io_out[15:GPIO_LSB] = out_reg;
      io_out[TX_IDX] = tx;
      io_oeb = '1;
      io_oeb[15:GPIO_LSB] = ~oe_reg;
      io_oeb[TX_IDX] = 1'b0;
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= io_in;
         sync2 <= sync1;
      end
   end

   // The timeout measures idle line time, so it is held clear while a byte is on the wire.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state       <= F_IDLE;
         cmd         <= '0;
         data        <= '0;
         snap        <= '0;
         out_reg     <= '0;
         oe_reg      <= '0;
         to_cnt      <= '0;
         frame_err_o <= 1'b0;
      end else begin
         frame_err_o <= rx_err || timeout;
         if (!in_frame || rx_valid || rx_busy) to_cnt <= '0;
         else if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
         case (state)
            F_IDLE: if (rx_valid && (rx_byte == CMD_WR || rx_byte == CMD_OE || rx_byte == CMD_RD)) begin
               cmd   <= rx_byte;
               state <= F_HI;
            end
            F_HI: if (rx_valid) begin
               data[13:6] <= rx_byte;
               state      <= F_LO;
            end else if (timeout) state <= F_IDLE;
            F_LO: if (rx_valid) begin
               data[5:0] <= rx_byte[7:2];
               state     <= F_EXEC;
            end else if (timeout) state <= F_IDLE;
            F_EXEC: begin
               state <= F_IDLE;
               if (cmd == CMD_WR) out_reg <= data;
               else if (cmd == CMD_OE) oe_reg <= data;
               else begin
                  snap  <= sync2;
                  state <= F_RESP_HI;
               end
            end
            F_RESP_HI: if (tx_done) state <= F_RESP_LO;
            F_RESP_LO: if (tx_done) state <= F_IDLE;
            default: state <= F_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_io_uart_gpio_bridge.sv
// Directed bench for io_uart_gpio_bridge with a fast UART (8 clocks per bit) and short frame timeout.
module tb_io_uart_gpio_bridge;
   localparam int CPB = 8;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_ni = 1'b0;
   logic [15:0] io_in = 16'h0001;
   logic [15:0] io_out, io_oeb;
   logic        frame_err_o;

   int n_cmp = 0;
   int n_bad = 0;
   int err_cnt = 0;

   io_uart_gpio_bridge #(.CLKS_PER_BIT(CPB), .FRAME_TO_BITS(4)) dut (
      .wb_clk_i    (wb_clk_i),
      .wb_rst_ni   (wb_rst_ni),
      .io_in       (io_in),
      .io_out      (io_out),
      .io_oeb      (io_oeb),
      .frame_err_o (frame_err_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   always @(negedge wb_clk_i) if (frame_err_o === 1'b1) err_cnt++;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic send_byte(input logic [7:0] b, input logic stop);
      @(negedge wb_clk_i);
      io_in[0] = 1'b0;
      repeat (CPB) @(negedge wb_clk_i);
      for (int i = 0; i < 8; i++) begin
         io_in[0] = b[i];
         repeat (CPB) @(negedge wb_clk_i);
      end
      io_in[0] = stop;
      repeat (CPB) @(negedge wb_clk_i);
      io_in[0] = 1'b1;
      repeat (3) @(negedge wb_clk_i);
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l);
      send_byte(c, 1'b1);
      send_byte(h, 1'b1);
      send_byte(l, 1'b1);
   endtask

   // Waits (bounded) for a start bit on TX, then samples each bit at its centre.
   task automatic recv_byte(output logic [7:0] b, output logic ok, output time t0);
      int n = 0;
      ok = 1'b1;
      b  = 8'h00;
      while (io_out[1] !== 1'b0 && n < 3000) begin
         @(negedge wb_clk_i);
         n++;
      end
      t0 = $time;
      if (n >= 3000) ok = 1'b0;
      else begin
         repeat (CPB / 2) @(negedge wb_clk_i);
         if (io_out[1] !== 1'b0) ok = 1'b0;
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge wb_clk_i);
            b[i] = io_out[1];
         end
         repeat (CPB) @(negedge wb_clk_i);
         if (io_out[1] !== 1'b1) ok = 1'b0;
      end
   endtask

   task automatic read_and_check(input string name, input logic [15:0] exp, input logic check_gap);
      logic [7:0] b0, b1;
      logic ok0, ok1;
      time t0, t1;
      fork
         send_frame(8'h52, 8'h00, 8'h00);
         begin
            recv_byte(b0, ok0, t0);
            recv_byte(b1, ok1, t1);
         end
      join
      n_cmp++;
      if (ok0 !== 1'b1 || b0 !== exp[15:8]) begin
         n_bad++;
         $display("FAIL %s_hi: got %h framing_ok=%b required %h framing_ok=1", name, b0, ok0, exp[15:8]);
      end
      n_cmp++;
      if (ok1 !== 1'b1 || b1 !== exp[7:0]) begin
         n_bad++;
         $display("FAIL %s_lo: got %h framing_ok=%b required %h framing_ok=1", name, b1, ok1, exp[7:0]);
      end
      if (check_gap) begin
         n_cmp++;
         if ((t1 - t0) / 10 < 80 || (t1 - t0) / 10 > 81) begin
            n_bad++;
            $display("FAIL %s_spacing: got %0d cycles between starts required 80..81", name, (t1 - t0) / 10);
         end
      end
   endtask

   task automatic test_reset();
      repeat (5) @(negedge wb_clk_i);
      wb_rst_ni = 1'b1;
      repeat (50) @(negedge wb_clk_i);
      n_cmp++;
      if (io_out !== 16'h0002) begin
         n_bad++;
         $display("FAIL reset_io_out: got %h required 0002", io_out);
      end
      n_cmp++;
      if (io_oeb !== 16'hFFFD) begin
         n_bad++;
         $display("FAIL reset_io_oeb: got %h required FFFD", io_oeb);
      end
      n_cmp++;
      if (err_cnt !== 0) begin
         n_bad++;
         $display("FAIL reset_frame_err: got %0d pulses required 0", err_cnt);
      end
   endtask

   task automatic test_write_regs();
      send_frame(8'h45, 8'hFF, 8'hFC);
      send_frame(8'h57, 8'hA5, 8'h5C);
      repeat (5) @(negedge wb_clk_i);
      n_cmp++;
      if (io_oeb !== 16'h0001) begin
         n_bad++;
         $display("FAIL write_io_oeb: got %h required 0001", io_oeb);
      end
      n_cmp++;
      if (io_out !== 16'hA55E) begin
         n_bad++;
         $display("FAIL write_io_out: got %h required A55E", io_out);
      end
      n_cmp++;
      if (err_cnt !== 0) begin
         n_bad++;
         $display("FAIL write_frame_err: got %0d pulses required 0", err_cnt);
      end
   endtask

   task automatic test_read();
      io_in[15:1] = 15'h1E40;
      read_and_check("read", 16'h3C81, 1'b1);
   endtask

   task automatic test_bad_stop();
      int base = err_cnt;
      send_byte(8'h57, 1'b0);
      repeat (10) @(negedge wb_clk_i);
      n_cmp++;
      if (err_cnt - base !== 1) begin
         n_bad++;
         $display("FAIL bad_stop_err: got %0d pulses required 1", err_cnt - base);
      end
      n_cmp++;
      if (io_out !== 16'hA55E || io_oeb !== 16'h0001) begin
         n_bad++;
         $display("FAIL bad_stop_regs: got out=%h oeb=%h required out=A55E oeb=0001", io_out, io_oeb);
      end
      send_frame(8'h57, 8'h00, 8'h0C);
      repeat (5) @(negedge wb_clk_i);
      n_cmp++;
      if (io_out !== 16'h000E) begin
         n_bad++;
         $display("FAIL after_bad_stop_write: got %h required 000E", io_out);
      end
   endtask

   task automatic test_timeout();
      int base = err_cnt;
      send_byte(8'h57, 1'b1);
      send_byte(8'h12, 1'b1);
      repeat (40) @(negedge wb_clk_i);
      n_cmp++;
      if (err_cnt - base !== 1) begin
         n_bad++;
         $display("FAIL timeout_err: got %0d pulses required 1", err_cnt - base);
      end
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      repeat (10) @(negedge wb_clk_i);
      n_cmp++;
      if (io_out !== 16'h000E) begin
         n_bad++;
         $display("FAIL timeout_orphan_bytes: got %h required 000E", io_out);
      end
      n_cmp++;
      if (err_cnt - base !== 1) begin
         n_bad++;
         $display("FAIL timeout_orphan_err: got %0d pulses required 1", err_cnt - base);
      end
   endtask

   task automatic test_reset_mid_tx();
      int n = 0;
      send_frame(8'h52, 8'h00, 8'h00);
      while (io_out[1] !== 1'b0 && n < 500) begin
         @(negedge wb_clk_i);
         n++;
      end
      n_cmp++;
      if (n >= 500) begin
         n_bad++;
         $display("FAIL midtx_start: got no start bit required start within 500 cycles");
      end
      repeat (20) @(negedge wb_clk_i);
      wb_rst_ni = 1'b0;
      #1;
      n_cmp++;
      if (io_out !== 16'h0002) begin
         n_bad++;
         $display("FAIL midtx_reset_io_out: got %h required 0002", io_out);
      end
      n_cmp++;
      if (io_oeb !== 16'hFFFD) begin
         n_bad++;
         $display("FAIL midtx_reset_io_oeb: got %h required FFFD", io_oeb);
      end
      repeat (3) @(negedge wb_clk_i);
      wb_rst_ni = 1'b1;
      repeat (5) @(negedge wb_clk_i);
      io_in[15:1] = 15'h52E1;
      read_and_check("post_reset_read", 16'hA5C3, 1'b0);
   endtask

   initial begin
      test_reset();
      test_write_regs();
      test_read();
      test_bad_stop();
      test_timeout();
      test_reset_mid_tx();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/io_uart_gpio_bridge.md
Name: io_uart_gpio_bridge

Overview:
- User-project core driven by the 16-pin IO slice of the user project wrapper.
- Slice index 0 is the UART RX pin and index 1 is the UART TX pin. Indices 15:2 are 14 GPIOs.
- A host drives 3-byte UART command frames to write GPIO output values and output enables, or to read back a snapshot of all 16 pad inputs.

Parameters:
- CLKS_PER_BIT, 434, wb_clk_i cycles per UART bit (115200 baud at 50 MHz); minimum 4.
- FRAME_TO_BITS, 40, idle bit-times allowed between bytes of one frame before the frame is abandoned.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_ni  in  1  asynchronous active-low reset; the wrapper drives it with ~wb_rst_i.
- io_in  in  16  pad inputs (slice order); [0]=RX, [15:2]=GPIO in.
- io_out  out  16  pad outputs; [1]=TX, [15:2]=GPIO out, [0]=0.
- io_oeb  out  16  active-low output enables.
- frame_err_o  out  1  one-cycle pulse when a byte or frame is dropped.

Behaviour:
- Reset values:
  - out_reg[13:0]=0 and oe_reg[13:0]=0, so all GPIOs are inputs and io_oeb[15:2]=1.
  - io_out[1]=1 (TX idle).
  - io_oeb[1]=0 and io_oeb[0]=1 at all times.
  - frame_err_o=0; all FSMs in IDLE.
- Reset mid-operation aborts any RX, TX or frame immediately; TX returns high asynchronously.
- Output mapping:
  - io_out[15:2]=out_reg.
  - io_oeb[15:2]=~oe_reg.
  - io_out[0]=0.
- Input sync: io_in passes through a 2-flop synchronizer (all 16 bits) before any use.
- RX: 8N1, LSB first.
  - Start is detected on a synchronized falling edge while in RX_IDLE.
  - Bit counter samples at CLKS_PER_BIT/2 into the start bit. If start reads high there, return to idle silently (glitch).
  - Data bits and stop bit are sampled every CLKS_PER_BIT thereafter.
  - If the stop bit reads 0, the byte is discarded and frame_err_o pulses. The RX FSM waits for the line to go high before re-arming.
  - A valid byte produces a one-cycle rx_valid with rx_byte.
- Frame FSM states: F_IDLE, F_HI, F_LO, F_EXEC, F_RESP_HI, F_RESP_LO.
  - F_IDLE: on a byte of 0x57 ('W'), 0x45 ('E') or 0x52 ('R'), latch cmd and go to F_HI. Any other byte is ignored with no error pulse.
  - F_HI latches data[15:8]; F_LO latches data[7:0]; then go to F_EXEC.
  - F_EXEC lasts one cycle:
    - 'W': out_reg<=data[15:2].
    - 'E': oe_reg<=data[15:2].
    - 'W' and 'E' return to F_IDLE.
    - 'R': snapshot the synchronized io_in[15:0], go to F_RESP_HI.
  - Data bits [1:0] are ignored.
  - New register values appear on io_out/io_oeb the cycle after F_EXEC.
- Response:
  - F_RESP_HI sends snap[15:8], then F_RESP_LO sends snap[7:0], then F_IDLE.
  - Each state issues tx_start when TX is idle and advances when TX completes.
  - Bytes received during F_RESP_* are dropped without error.
- Frame timeout:
  - In F_HI or F_LO, a counter clears on every rx_valid.
  - When it reaches FRAME_TO_BITS*CLKS_PER_BIT cycles, the FSM returns to F_IDLE and frame_err_o pulses.
  - A timeout and an rx_valid in the same cycle: the byte wins and the counter clears.
- TX: 8N1, LSB first.
  - Start bit, 8 data bits and stop bit, each exactly CLKS_PER_BIT cycles.
  - Busy from tx_start until the end of the stop bit.
  - Back-to-back bytes may start the cycle after stop completes.
- Counters use $clog2-sized widths.
  - Bit counters are 4-bit.
  - The timeout counter saturates and never wraps.

Decomposition:
- Package io_uart_gpio_pkg holds:
  - command byte constants CMD_WR=8'h57, CMD_OE=8'h45, CMD_RD=8'h52;
  - the frame FSM state enum;
  - pin index constants RX_IDX=0, TX_IDX=1, GPIO_LSB=2.
- Sub-module uart_8n1 contains the RX and TX engines, parameterized by CLKS_PER_BIT. The top module holds the synchronizer, the frame FSM and the registers.

Test Plan (CLKS_PER_BIT=8, FRAME_TO_BITS=4):
- Reset, then idle 50 cycles -> io_out=16'h0002, io_oeb=16'hFFFD, frame_err_o never asserted.
- Send 0x45,0xFF,0xFC, then 0x57,0xA5,0x5C -> io_oeb=16'h0001 and io_out=16'hA55E (bit1 TX idle high).
- Drive io_in=16'h3C81 and send 0x52,0x00,0x00 -> TX emits 0x3C then 0x81, 8N1, 80 cycles per byte, with no gap beyond 1 cycle.
- Send 0x57 with the stop bit forced low -> frame_err_o pulses once, registers unchanged. A following valid 'W' frame 0x57,0x00,0x0C is accepted -> io_out[15:2]=14'h0003.
- Send 0x57,0x12 then idle 40 cycles -> frame_err_o pulses once. Then 0x12,0x34 alone -> ignored, io_out unchanged.
- Assert wb_rst_ni low mid-byte of a read response -> TX high within the reset, out_reg/oe_reg cleared. After release, a new 'R' frame responds correctly.
